rr_mux_arbiter: RTL

- Round-robin arbiter and sequencer for a shared N:1 data mux (index-selected, as in mux_4_1), N = 4.
- Four requesters present data with valid/ready; the block picks one per cycle, drives the mux select, and registers the selected word into a single output stage with valid/ready.
- Sits between independent producers and one shared downstream consumer.

---
 rtl/rr_mux_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a 4:1 data mux into a single registered output stage
// with valid/ready handshakes on both sides.
module rr_mux_arbiter #(
  parameter int WIDTH = 4,
  parameter int N     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       in_valid,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  input  logic [WIDTH-1:0] in_data2,
  input  logic [WIDTH-1:0] in_data3,
  output logic [3:0]       in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src,
  input  logic             out_ready,
  output logic [1:0]       sel
);

  logic [1:0]       ptr;
  logic [1:0]       winner;
  logic [1:0]       idx;
  logic             found;
  logic             any_valid;
  logic             free;
  logic             grant;
  logic [WIDTH-1:0] mux_data;

  // Search starts at ptr and wraps; falls back to ptr when nobody requests.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && in_valid[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign any_valid = |in_valid;
  assign free      = !out_valid || out_ready;
  // rst_n gating keeps in_ready low for the whole reset interval, not just after it.
  assign grant     = rst_n && free && any_valid;
  assign sel       = winner;

  always_comb begin
    in_ready = 4'b0000;
    if (grant) in_ready[winner] = 1'b1;
  end

  always_comb begin
    mux_data = in_data0;
    case (sel)
      2'd0: mux_data = in_data0;
      2'd1: mux_data = in_data1;
      2'd2: mux_data = in_data2;
      2'd3: mux_data = in_data3;
      default: mux_data = in_data0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      ptr       <= 2'd0;
    end else if (grant) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_src   <= winner;
      ptr       <= winner + 2'd1;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

endmodule
